// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
//   Sole owner of the character-LCD pin bus. After reset it waits INIT_WAIT
//   cycles, issues the four-command power-on init sequence, then shares the
//   bus between two byte-wide requesters using round-robin arbitration.
//   Every write (init or requester) is a timed sequence:
//     S_SETUP (1 cycle) -> S_PULSE (E_HIGH cycles, E=1) -> S_WAIT (settle).
//   The settle time is CLEAR_WAIT for clear/home commands, else CMD_WAIT.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   i_req0/i_rs0/i_data0: channel 0 request (held until o_ack0), RS, byte
//   o_ack0              : channel 0 one-cycle completion pulse
//   i_req1/i_rs1/i_data1: channel 1 request (held until o_ack1), RS, byte
//   o_ack1              : channel 1 one-cycle completion pulse
//   o_init_done         : sticky high once the init sequence has completed
//   o_busy              : high whenever the arbiter is not idle
//   o_lcd_e/o_lcd_rs/o_lcd_rw/o_lcd_data : LCD pins (RW tied to write)
// ---------------------------------------------------------------------------
module lcd_bus_arbiter #(
    parameter int unsigned INIT_WAIT  = 70,
    parameter int unsigned E_HIGH     = 2,
    parameter int unsigned CMD_WAIT   = 4,
    parameter int unsigned CLEAR_WAIT = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req0,
    input  logic       i_rs0,
    input  logic [7:0] i_data0,
    output logic       o_ack0,
    input  logic       i_req1,
    input  logic       i_rs1,
    input  logic [7:0] i_data1,
    output logic       o_ack1,
    output logic       o_init_done,
    output logic       o_busy,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned NUM_INIT  = 4;

    // Terminal counter values (each phase lasts LAST+1 cycles).
    localparam logic [CNT_W-1:0] INIT_LAST  = (INIT_WAIT  > 0) ? CNT_W'(INIT_WAIT  - 1) : '0;
    localparam logic [CNT_W-1:0] PULSE_LAST = (E_HIGH     > 0) ? CNT_W'(E_HIGH     - 1) : '0;
    localparam logic [CNT_W-1:0] CMD_LAST   = (CMD_WAIT   > 0) ? CNT_W'(CMD_WAIT   - 1) : '0;
    localparam logic [CNT_W-1:0] CLEAR_LAST = (CLEAR_WAIT > 0) ? CNT_W'(CLEAR_WAIT - 1) : '0;
    localparam logic [IDX_W-1:0] INIT_IDX_LAST = IDX_W'(NUM_INIT - 1);

    typedef enum logic [2:0] {
        S_INIT_WAIT = 3'd0,
        S_IDLE      = 3'd1,
        S_SETUP     = 3'd2,
        S_PULSE     = 3'd3,
        S_WAIT      = 3'd4
    } state_t;

    // Who owns the write currently on the bus.
    typedef enum logic [1:0] {
        SRC_INIT = 2'd0,
        SRC_CH0  = 2'd1,
        SRC_CH1  = 2'd2
    } src_t;

    // Power-on init commands: function set, display on, entry mode, clear.
    function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = 8'h38;
            3'd1:    cmd = 8'h0C;
            3'd2:    cmd = 8'h06;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    // Registered state and datapath
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_init_idx;
    logic               r_last_grant;
    src_t               r_src;
    logic               r_rs;
    logic [7:0]         r_data;
    logic               r_init_done;
    logic               r_ack0;
    logic               r_ack1;
    logic               r_busy;
    logic               r_lcd_e;

    // Next-state values
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_init_idx_nxt;
    logic               w_last_grant_nxt;
    src_t               w_src_nxt;
    logic               w_rs_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_init_done_nxt;
    logic               w_pick1;

    // Next output values
    logic               w_ack0_nxt;
    logic               w_ack1_nxt;
    logic               w_busy_nxt;
    logic               w_lcd_e_nxt;

    logic               w_long_wait;
    logic [CNT_W-1:0]   w_wait_last;

    // Clear (0x01) and home (0x02) commands need the long settle time.
    assign w_long_wait = ~r_rs && ((r_data == 8'h01) || (r_data == 8'h02));
    assign w_wait_last = w_long_wait ? CLEAR_LAST : CMD_LAST;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_INIT_WAIT;
            r_cnt        <= '0;
            r_init_idx   <= '0;
            r_last_grant <= 1'b1;
            r_src        <= SRC_INIT;
            r_rs         <= 1'b0;
            r_data       <= 8'h00;
            r_init_done  <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b1;
            r_lcd_e      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_init_idx   <= w_init_idx_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_src        <= w_src_nxt;
            r_rs         <= w_rs_nxt;
            r_data       <= w_data_nxt;
            r_init_done  <= w_init_done_nxt;
            r_ack0       <= w_ack0_nxt;
            r_ack1       <= w_ack1_nxt;
            r_busy       <= w_busy_nxt;
            r_lcd_e      <= w_lcd_e_nxt;
        end
    end

    // Next-state, phase counter, arbitration and write latch
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_init_idx_nxt   = r_init_idx;
        w_last_grant_nxt = r_last_grant;
        w_src_nxt        = r_src;
        w_rs_nxt         = r_rs;
        w_data_nxt       = r_data;
        w_init_done_nxt  = r_init_done;
        // On a tie, channel 1 wins only if channel 0 had the last grant.
        w_pick1          = i_req1 && (!i_req0 || !r_last_grant);

        case (r_state)
            S_INIT_WAIT: begin
                if (r_cnt >= INIT_LAST) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = '0;
                    w_src_nxt   = SRC_INIT;
                    w_rs_nxt    = 1'b0;
                    w_data_nxt  = init_cmd(r_init_idx);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_IDLE: begin
                w_cnt_nxt = '0;
                if (i_req0 || i_req1) begin
                    w_state_nxt      = S_SETUP;
                    w_last_grant_nxt = w_pick1;
                    w_src_nxt        = w_pick1 ? SRC_CH1 : SRC_CH0;
                    w_rs_nxt         = w_pick1 ? i_rs1   : i_rs0;
                    w_data_nxt       = w_pick1 ? i_data1 : i_data0;
                end
            end

            S_SETUP: begin
                w_state_nxt = S_PULSE;
                w_cnt_nxt   = '0;
            end

            S_PULSE: begin
                if (r_cnt >= PULSE_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_WAIT: begin
                if (r_cnt >= w_wait_last) begin
                    w_cnt_nxt = '0;
                    if (r_src == SRC_INIT) begin
                        w_init_idx_nxt = r_init_idx + IDX_W'(1);
                        if (r_init_idx == INIT_IDX_LAST) begin
                            w_state_nxt     = S_IDLE;
                            w_init_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_SETUP;
                            w_rs_nxt    = 1'b0;
                            w_data_nxt  = init_cmd(r_init_idx + IDX_W'(1));
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_INIT_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the FSM is heading
    always_comb begin
        w_lcd_e_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;

        w_lcd_e_nxt = (w_state_nxt == S_PULSE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        // Ack lands on the final settle cycle; the latched RS/DATA do not
        // change between S_PULSE and S_WAIT so the current wait length holds.
        if ((w_state_nxt == S_WAIT) && (w_cnt_nxt == w_wait_last)) begin
            w_ack0_nxt = (r_src == SRC_CH0);
            w_ack1_nxt = (r_src == SRC_CH1);
        end
    end

    assign o_ack0      = r_ack0;
    assign o_ack1      = r_ack1;
    assign o_init_done = r_init_done;
    assign o_busy      = r_busy;
    assign o_lcd_e     = r_lcd_e;
    assign o_lcd_rs    = r_rs;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = r_data;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_arbiter
//   Reference model: a queue of expected per-cycle pin/ack/busy values. Each
//   granted write appends its whole waveform (setup, E-high, settle with ack
//   on the last settle cycle); an empty queue means idle. Every cycle the
//   DUT outputs are compared with the head of that schedule.
// ---------------------------------------------------------------------------
module tb_lcd_bus_arbiter;

    localparam int unsigned INIT_WAIT  = 70;
    localparam int unsigned E_HIGH     = 2;
    localparam int unsigned CMD_WAIT   = 4;
    localparam int unsigned CLEAR_WAIT = 40;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       req0  = 1'b0;
    logic       rs0   = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       req1  = 1'b0;
    logic       rs1   = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, init_done, busy, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_bus_arbiter #(
        .INIT_WAIT (INIT_WAIT),
        .E_HIGH    (E_HIGH),
        .CMD_WAIT  (CMD_WAIT),
        .CLEAR_WAIT(CLEAR_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req0     (req0),
        .i_rs0      (rs0),
        .i_data0    (data0),
        .o_ack0     (ack0),
        .i_req1     (req1),
        .i_rs1      (rs1),
        .i_data1    (data1),
        .o_ack1     (ack1),
        .o_init_done(init_done),
        .o_busy     (busy),
        .o_lcd_e    (lcd_e),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic [7:0] d;
        logic       busy;
        logic       a0;
        logic       a1;
    } exp_t;

    exp_t       mq[$];
    exp_t       cur;
    bit         m_valid = 1'b0;
    bit         m_done  = 1'b0;
    int         m_last  = 1;
    int         cyc     = 0;
    logic [7:0] init_cmds [4];

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state (since the most recent reset)
    logic [7:0] rise_data[$];
    logic       rise_rs[$];
    int         rise_cyc[$];
    int         run_len[$];
    int         run = 0;
    bit         prev_e = 1'b0;
    bit         prev_done = 1'b0;
    int         pre_acks = 0;
    int         n_ack1 = 0;
    int         done_cyc = 0;
    int         rises_at_done = 0;

    initial begin
        init_cmds[0] = 8'h38;
        init_cmds[1] = 8'h0C;
        init_cmds[2] = 8'h06;
        init_cmds[3] = 8'h01;
    end

    // Append the full waveform of one write. src: 0=init, 1=ch0, 2=ch1.
    task automatic push_write(input int src, input logic rs, input logic [7:0] d);
        exp_t x;
        int   w;
        w = (!rs && (d == 8'h01 || d == 8'h02)) ? int'(CLEAR_WAIT) : int'(CMD_WAIT);
        x = '{e: 1'b0, rs: rs, d: d, busy: 1'b1, a0: 1'b0, a1: 1'b0};
        mq.push_back(x);
        x.e = 1'b1;
        for (int i = 0; i < int'(E_HIGH); i++) mq.push_back(x);
        x.e = 1'b0;
        for (int i = 0; i < w; i++) begin
            x.a0 = (i == w - 1) && (src == 1);
            x.a1 = (i == w - 1) && (src == 2);
            mq.push_back(x);
        end
    endtask

    // Reference model, advanced on every active edge.
    always @(posedge clk) begin
        if (rst) begin
            cyc     <= 1;
            mq.delete();
            m_valid = 1'b1;
            m_done  = 1'b0;
            m_last  = 1;
            cur     = '{e: 1'b0, rs: 1'b0, d: 8'h00, busy: 1'b1, a0: 1'b0, a1: 1'b0};
            for (int i = 1; i < int'(INIT_WAIT); i++) mq.push_back(cur);
            for (int i = 0; i < 4; i++) push_write(0, 1'b0, init_cmds[i]);
        end else if (m_valid) begin
            int ch;
            cyc <= cyc + 1;
            if (!cur.busy && (req0 || req1)) begin
                if (req0 && req1) ch = (m_last == 1) ? 0 : 1;
                else              ch = req0 ? 0 : 1;
                m_last = ch;
                if (ch == 0) push_write(1, rs0, data0);
                else         push_write(2, rs1, data1);
            end
            if (mq.size() != 0) begin
                cur = mq.pop_front();
            end else begin
                cur.e    = 1'b0;
                cur.busy = 1'b0;
                cur.a0   = 1'b0;
                cur.a1   = 1'b0;
                m_done   = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample on the falling edge, compare against the model,
    // update the monitor, then return just after the edge for driving.
    task automatic tick();
        @(negedge clk);
        if (m_valid) begin
            check("lcd_e",     int'(lcd_e),     int'(cur.e));
            check("lcd_rs",    int'(lcd_rs),    int'(cur.rs));
            check("lcd_data",  int'(lcd_data),  int'(cur.d));
            check("lcd_rw",    int'(lcd_rw),    0);
            check("busy",      int'(busy),      int'(cur.busy));
            check("ack0",      int'(ack0),      int'(cur.a0));
            check("ack1",      int'(ack1),      int'(cur.a1));
            check("init_done", int'(init_done), int'(m_done));
        end
        if (rst) begin
            rise_data.delete();
            rise_rs.delete();
            rise_cyc.delete();
            run_len.delete();
            run           = 0;
            prev_e        = 1'b0;
            prev_done     = 1'b0;
            pre_acks      = 0;
            n_ack1        = 0;
            done_cyc      = 0;
            rises_at_done = 0;
        end else begin
            if (lcd_e) begin
                if (!prev_e) begin
                    rise_data.push_back(lcd_data);
                    rise_rs.push_back(lcd_rs);
                    rise_cyc.push_back(cyc);
                    run = 0;
                end
                run++;
            end else if (prev_e) begin
                run_len.push_back(run);
            end
            prev_e = lcd_e;
            if (!init_done && (ack0 || ack1)) pre_acks++;
            if (ack1) n_ack1++;
            if (init_done && !prev_done) begin
                done_cyc      = cyc;
                rises_at_done = rise_data.size();
            end
            prev_done = init_done;
        end
        #1;
    endtask

    task automatic reset_dut();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        rst  = 1'b0;
    endtask

    // Wait until the model says the bus is initialised and idle.
    task automatic wait_ready(input int maxc);
        int n = 0;
        while (!(m_done && !cur.busy) && n < maxc) begin
            tick();
            n++;
        end
        check("wait_ready", int'(m_done && !cur.busy), 1);
    endtask

    // Issue one write from an idle cycle; latency = ack cycle - grant cycle.
    task automatic do_write(input int ch, input logic rs, input logic [7:0] d,
                            output int lat, output logic [7:0] setup_d, output logic setup_rs);
        int t;
        lat = -1;
        setup_d = 8'h00;
        setup_rs = 1'b0;
        t = cyc;
        if (ch == 0) begin req0 = 1'b1; rs0 = rs; data0 = d; end
        else         begin req1 = 1'b1; rs1 = rs; data1 = d; end
        for (int n = 0; n < 100; n++) begin
            tick();
            if (n == 0) begin
                setup_d  = lcd_data;
                setup_rs = lcd_rs;
                // Input changes after grant must not disturb the write.
                if (ch == 0) data0 = ~d; else data1 = ~d;
            end
            if ((ch == 0) ? ack0 : ack1) begin
                lat = cyc - t;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    function automatic logic [7:0] rbyte();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
        return 8'($urandom);
    endfunction

    initial begin
        int         lat;
        logic [7:0] sd;
        logic       srs;
        int         order[$];
        int         exp_order[4];
        int         acyc;
        bit         got;

        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

        // Reset values and the init sequence with no requests
        tick();
        check("rst_busy",      int'(busy),      1);
        check("rst_init_done", int'(init_done), 0);
        check("rst_lcd_data",  int'(lcd_data),  0);
        check("rst_lcd_e",     int'(lcd_e),     0);
        tick();
        rst = 1'b0;
        wait_ready(400);
        check("init_rises", rise_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rise_data.size()) begin
                check("init_cmd", int'(rise_data[i]), int'(init_cmds[i]));
                check("init_rs",  int'(rise_rs[i]),   0);
            end
            if (i < run_len.size()) check("init_e_len", run_len[i], int'(E_HIGH));
        end
        if (rise_cyc.size() > 0) check("first_e_cycle", rise_cyc[0], int'(INIT_WAIT) + 2);
        check("init_done_cycle", done_cyc, 135);

        // Single data write on ch0
        do_write(0, 1'b1, 8'h54, lat, sd, srs);
        check("ch0_latency",  lat, 7);
        check("ch0_setup_d",  int'(sd), 8'h54);
        check("ch0_setup_rs", int'(srs), 1);
        tick();
        check("ch0_idle_after", int'(busy), 0);

        // Clear command vs normal command wait on ch1
        wait_ready(100);
        do_write(1, 1'b0, 8'h01, lat, sd, srs);
        check("ch1_clear_latency", lat, 43);
        wait_ready(100);
        do_write(1, 1'b0, 8'h80, lat, sd, srs);
        check("ch1_cmd_latency", lat, 7);

        // Round-robin with both requests held
        reset_dut();
        wait_ready(400);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h30;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h31;
        for (int n = 0; n < 200 && order.size() < 4; n++) begin
            tick();
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < order.size()) check("rr_order", order[i], exp_order[i]);

        // Request pending through init is served right after init_done
        reset_dut();
        repeat (5) tick();
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        acyc = -1;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (ack0) begin acyc = cyc; break; end
        end
        req0 = 1'b0;
        check("pend_ack_cycle",   acyc, done_cyc + 7);
        check("pend_pre_acks",    pre_acks, 0);
        check("pend_init_rises",  rises_at_done, 4);

        // Reset in the middle of a ch1 E pulse
        wait_ready(100);
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h55;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (lcd_e) begin got = 1'b1; break; end
        end
        check("mid_pulse_seen", int'(got), 1);
        rst  = 1'b1;
        req1 = 1'b0;
        tick();
        check("mid_rst_e",         int'(lcd_e),     0);
        check("mid_rst_data",      int'(lcd_data),  0);
        check("mid_rst_busy",      int'(busy),      1);
        check("mid_rst_init_done", int'(init_done), 0);
        rst = 1'b0;
        wait_ready(400);
        if (rise_data.size() > 0) check("mid_rst_restart", int'(rise_data[0]), 8'h38);
        check("mid_rst_no_ack1", n_ack1, 0);

        // Randomised traffic, including early drops, held requests and resets
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 1499) == 0) begin
                reset_dut();
                continue;
            end
            tick();
            if (req0) begin
                if (ack0) begin
                    if ($urandom_range(0, 3) == 0) data0 = rbyte();
                    else req0 = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    req0 = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    data0 = rbyte();
                    rs0   = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 5) == 0) begin
                req0  = 1'b1;
                rs0   = 1'($urandom_range(0, 1));
                data0 = rbyte();
            end
            if (req1) begin
                if (ack1) begin
                    if ($urandom_range(0, 3) == 0) data1 = rbyte();
                    else req1 = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    req1 = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    data1 = rbyte();
                    rs1   = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 5) == 0) begin
                req1  = 1'b1;
                rs1   = 1'($urandom_range(0, 1));
                data1 = rbyte();
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (60) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
